// File: rtl/dcache_store_buffer_pkg.sv
// -----------------------------------------------------------------------------
// dcache_store_buffer_pkg
//   Shared types and constants for the DCache store buffer and for any other
//   write buffer that reuses the sb_conflict_check sub-module.
//   Contents:
//     SB_DEPTH_DEFAULT : default number of buffer entries
//     SB_ADDR_W        : physical address width the entry type is sized for
//     sb_entry_t       : one buffered word store (valid, word address, byte
//                        enables, lane-aligned data)
//     sb_merge_data    : byte-wise overlay of new store data onto an entry
// -----------------------------------------------------------------------------
package dcache_store_buffer_pkg;

   localparam int SB_DEPTH_DEFAULT = 4;
   localparam int SB_ADDR_W        = 32;

   typedef struct packed {
      logic                   valid;
      logic [SB_ADDR_W-1:2]   waddr;
      logic [3:0]             wen;
      logic [31:0]            data;
   } sb_entry_t;

   // Replace only the byte lanes enabled in ben; other lanes keep old data.
   function automatic logic [31:0] sb_merge_data(
      input logic [31:0] old_data,
      input logic [31:0] new_data,
      input logic [3:0]  ben
   );
      logic [31:0] result;
      result = old_data;
      for (int b = 0; b < 4; b++) begin
         if (ben[b]) begin
            result[8*b +: 8] = new_data[8*b +: 8];
         end else begin
            result[8*b +: 8] = old_data[8*b +: 8];
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/dcache_store_buffer_sb_conflict_check.sv
// -----------------------------------------------------------------------------
// sb_conflict_check
//   Combinational load-vs-buffer overlap detector. Each valid entry is compared
//   on word address and byte-enable overlap; the per-entry hits are OR-reduced
//   and qualified by the load valid.
//   Ports:
//     entries  in   DEPTH buffer entries (sb_entry_t)
//     ld_valid in   a load is querying this cycle
//     ld_waddr in   word address of the load (address bits [SB_ADDR_W-1:2])
//     ld_ben   in   bytes the load reads
//     conflict out  load overlaps at least one valid entry
// -----------------------------------------------------------------------------
module sb_conflict_check
   import dcache_store_buffer_pkg::*;
#(
   parameter int DEPTH = SB_DEPTH_DEFAULT
) (
   input  sb_entry_t            entries [DEPTH],
   input  logic                 ld_valid,
   input  logic [SB_ADDR_W-1:2] ld_waddr,
   input  logic [3:0]           ld_ben,
   output logic                 conflict
);

   logic [DEPTH-1:0] hit_vec_s;

   // Per-entry overlap: same word and at least one shared byte lane.
   always_comb begin
      hit_vec_s = {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
         hit_vec_s[i] = entries[i].valid
                        && (entries[i].waddr == ld_waddr)
                        && ((entries[i].wen & ld_ben) != 4'b0000);
      end
   end

   assign conflict = ld_valid && (|hit_vec_s);

endmodule

// File: rtl/dcache_store_buffer.sv
// -----------------------------------------------------------------------------
// dcache_store_buffer
//   In-order FIFO of word-aligned stores between MEM1 and the DCache write port.
//   Stores drain one per dc_valid/dc_ready handshake; loads that overlap any
//   buffered store raise ld_conflict so MEM1 can stall until the store drains.
//
//   Optional feature (macro STORE_BUF_MERGE_EN): a store to the same word as the
//   youngest valid entry is merged into it instead of allocating, unless that
//   entry is the head and is being popped this cycle. A merging store is
//   accepted even when the buffer is full.
//
//   Ports:
//     clk, resetn                  clock, synchronous active-low reset
//     push_valid/ready/addr/wen/data  store from MEM1 (addr bits [1:0] ignored)
//     dc_valid/ready/addr/wen/data    oldest entry to the DCache write port
//     ld_valid/addr/ben               load query from MEM1
//     ld_conflict                     load overlaps a buffered entry (comb.)
//     empty, full                     occupancy flags
// -----------------------------------------------------------------------------
module dcache_store_buffer
   import dcache_store_buffer_pkg::*;
#(
   parameter int DEPTH  = SB_DEPTH_DEFAULT,
   parameter int ADDR_W = SB_ADDR_W
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              push_valid,
   output logic              push_ready,
   input  logic [ADDR_W-1:0] push_addr,
   input  logic [3:0]        push_wen,
   input  logic [31:0]       push_data,
   output logic              dc_valid,
   input  logic              dc_ready,
   output logic [ADDR_W-1:0] dc_addr,
   output logic [3:0]        dc_wen,
   output logic [31:0]       dc_data,
   input  logic              ld_valid,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [3:0]        ld_ben,
   output logic              ld_conflict,
   output logic              empty,
   output logic              full
);

   localparam int                PTR_W      = $clog2(DEPTH);
   localparam int                WA_W       = SB_ADDR_W - 2;
   localparam logic [PTR_W:0]    FULL_COUNT = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W-1:0]  PTR_ONE    = PTR_W'(1);

   sb_entry_t          entries_r [DEPTH];
   logic [PTR_W-1:0]   head_r;
   logic [PTR_W-1:0]   tail_r;
   logic [PTR_W:0]     count_r;

   logic               empty_s;
   logic               full_s;
   logic               pop_s;
   logic               push_fire_s;
   logic               alloc_s;
   logic               merge_hit_s;
   logic               merge_fire_s;
   logic               conflict_s;
   logic [PTR_W-1:0]   youngest_s;
   logic [WA_W-1:0]    push_waddr_s;
   logic [WA_W-1:0]    ld_waddr_s;
   logic               unused_s;

   assign push_waddr_s = WA_W'(push_addr[ADDR_W-1:2]);
   assign ld_waddr_s   = WA_W'(ld_addr[ADDR_W-1:2]);
   assign empty_s      = (count_r == {(PTR_W+1){1'b0}});
   assign full_s       = (count_r == FULL_COUNT);
   assign youngest_s   = tail_r - PTR_ONE;

`ifdef STORE_BUF_MERGE_EN
   // Merge target is the youngest entry, unless it is leaving this very cycle.
   always_comb begin
      merge_hit_s = 1'b0;
      if (resetn && !empty_s) begin
         merge_hit_s = (entries_r[youngest_s].waddr == push_waddr_s)
                       && !((youngest_s == head_r) && pop_s);
      end else begin
         merge_hit_s = 1'b0;
      end
   end
   assign unused_s = ^{push_addr[1:0], ld_addr[1:0]};
`else
   assign merge_hit_s = 1'b0;
   assign unused_s    = ^{push_addr[1:0], ld_addr[1:0], youngest_s};
`endif

   // Handshake and status outputs; reset forces the idle view immediately.
   always_comb begin
      empty      = 1'b1;
      full       = 1'b0;
      dc_valid   = 1'b0;
      push_ready = 1'b1;
      if (resetn) begin
         empty      = empty_s;
         full       = full_s;
         dc_valid   = !empty_s;
         push_ready = !full_s || merge_hit_s;
      end else begin
         empty      = 1'b1;
         full       = 1'b0;
         dc_valid   = 1'b0;
         push_ready = 1'b1;
      end
   end

   // Head entry presented to the DCache; zeroed while nothing is valid.
   always_comb begin
      dc_addr = {ADDR_W{1'b0}};
      dc_wen  = 4'b0000;
      dc_data = 32'h0000_0000;
      if (dc_valid) begin
         dc_addr = ADDR_W'({entries_r[head_r].waddr, 2'b00});
         dc_wen  = entries_r[head_r].wen;
         dc_data = entries_r[head_r].data;
      end else begin
         dc_addr = {ADDR_W{1'b0}};
         dc_wen  = 4'b0000;
         dc_data = 32'h0000_0000;
      end
   end

   // A zero-enable push is accepted by the handshake but never stored.
   assign pop_s        = dc_valid && dc_ready;
   assign push_fire_s  = push_valid && push_ready && (push_wen != 4'b0000);
   assign merge_fire_s = push_fire_s && merge_hit_s;
   assign alloc_s      = push_fire_s && !merge_hit_s;

   sb_conflict_check #(
      .DEPTH    (DEPTH)
   ) u_conflict (
      .entries  (entries_r),
      .ld_valid (ld_valid),
      .ld_waddr (ld_waddr_s),
      .ld_ben   (ld_ben),
      .conflict (conflict_s)
   );

   // Entries popped this cycle are still in entries_r, so they still conflict.
   assign ld_conflict = resetn && conflict_s;

   // Pointer, count and entry storage update.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         head_r  <= {PTR_W{1'b0}};
         tail_r  <= {PTR_W{1'b0}};
         count_r <= {(PTR_W+1){1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            entries_r[i] <= '{valid: 1'b0, waddr: {WA_W{1'b0}},
                              wen: 4'b0000, data: 32'h0000_0000};
         end
      end else begin
         // Alloc implies not full and pop implies not empty, so the alloc slot
         // and the popped slot are never the same entry.
         if (pop_s) begin
            entries_r[head_r].valid <= 1'b0;
            head_r                  <= head_r + PTR_ONE;
         end else begin
            head_r <= head_r;
         end
         if (alloc_s) begin
            entries_r[tail_r] <= '{valid: 1'b1, waddr: push_waddr_s,
                                   wen: push_wen, data: push_data};
            tail_r            <= tail_r + PTR_ONE;
         end else begin
            tail_r <= tail_r;
         end
         if (merge_fire_s) begin
            entries_r[youngest_s].wen  <= entries_r[youngest_s].wen | push_wen;
            entries_r[youngest_s].data <= sb_merge_data(entries_r[youngest_s].data,
                                                        push_data, push_wen);
         end
         case ({alloc_s, pop_s})
            2'b10:   count_r <= count_r + {{PTR_W{1'b0}}, 1'b1};
            2'b01:   count_r <= count_r - {{PTR_W{1'b0}}, 1'b1};
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: tb/tb_dcache_store_buffer.sv
// -----------------------------------------------------------------------------
// tb_dcache_store_buffer
//   Self-checking bench: directed sequences with literal expectations, then
//   randomized traffic. A queue-based model predicts every output each cycle.
// -----------------------------------------------------------------------------
module tb_dcache_store_buffer;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        resetn;
   logic        push_valid;
   logic        push_ready;
   logic [31:0] push_addr;
   logic [3:0]  push_wen;
   logic [31:0] push_data;
   logic        dc_valid;
   logic        dc_ready;
   logic [31:0] dc_addr;
   logic [3:0]  dc_wen;
   logic [31:0] dc_data;
   logic        ld_valid;
   logic [31:0] ld_addr;
   logic [3:0]  ld_ben;
   logic        ld_conflict;
   logic        empty;
   logic        full;

   int n_vec = 0;
   int n_mis = 0;

   // Reference model: program-order queue of buffered stores.
   logic [31:0] qa [$];
   logic [3:0]  qw [$];
   logic [31:0] qd [$];

   dcache_store_buffer #(.DEPTH(DEPTH), .ADDR_W(32)) dut (
      .clk(clk), .resetn(resetn),
      .push_valid(push_valid), .push_ready(push_ready), .push_addr(push_addr),
      .push_wen(push_wen), .push_data(push_data),
      .dc_valid(dc_valid), .dc_ready(dc_ready), .dc_addr(dc_addr),
      .dc_wen(dc_wen), .dc_data(dc_data),
      .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_ben(ld_ben),
      .ld_conflict(ld_conflict), .empty(empty), .full(full)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic model_merge();
`ifdef STORE_BUF_MERGE_EN
      int n = qa.size();
      if (!resetn || n == 0) return 1'b0;
      if (qa[n-1][31:2] != push_addr[31:2]) return 1'b0;
      // The single remaining entry is leaving this cycle: cannot merge into it.
      if (n == 1 && dc_ready) return 1'b0;
      return 1'b1;
`else
      return 1'b0;
`endif
   endfunction

   task automatic check_outputs();
      int          n = qa.size();
      logic        e_valid, e_full, e_empty, e_ready, e_conf;
      logic [31:0] e_addr, e_data;
      logic [3:0]  e_wen;
      if (!resetn) begin
         e_valid = 1'b0; e_full = 1'b0; e_empty = 1'b1; e_ready = 1'b1;
         e_conf = 1'b0; e_addr = 32'h0; e_wen = 4'h0; e_data = 32'h0;
      end else begin
         e_valid = (n > 0);
         e_full  = (n == DEPTH);
         e_empty = (n == 0);
         e_ready = !e_full || model_merge();
         e_addr  = (n > 0) ? qa[0] : 32'h0;
         e_wen   = (n > 0) ? qw[0] : 4'h0;
         e_data  = (n > 0) ? qd[0] : 32'h0;
         e_conf  = 1'b0;
         if (ld_valid) begin
            for (int i = 0; i < n; i++) begin
               if (qa[i][31:2] == ld_addr[31:2] && (qw[i] & ld_ben) != 4'h0) e_conf = 1'b1;
            end
         end
      end
      chk("dc_valid", {31'h0, dc_valid}, {31'h0, e_valid});
      chk("full", {31'h0, full}, {31'h0, e_full});
      chk("empty", {31'h0, empty}, {31'h0, e_empty});
      chk("push_ready", {31'h0, push_ready}, {31'h0, e_ready});
      chk("ld_conflict", {31'h0, ld_conflict}, {31'h0, e_conf});
      chk("dc_addr", dc_addr, e_addr);
      chk("dc_wen", {28'h0, dc_wen}, {28'h0, e_wen});
      chk("dc_data", dc_data, e_data);
   endtask

   task automatic update_model();
      int   n;
      logic mh, pop, fire;
      n = qa.size();
      if (!resetn) begin
         qa.delete(); qw.delete(); qd.delete();
      end else begin
         mh   = model_merge();
         pop  = (n > 0) && dc_ready;
         fire = push_valid && ((n < DEPTH) || mh) && (push_wen != 4'h0);
         if (fire && mh) begin
            for (int b = 0; b < 4; b++) begin
               if (push_wen[b]) qd[n-1][8*b +: 8] = push_data[8*b +: 8];
            end
            qw[n-1] = qw[n-1] | push_wen;
         end
         if (pop) begin
            void'(qa.pop_front()); void'(qw.pop_front()); void'(qd.pop_front());
         end
         if (fire && !mh) begin
            qa.push_back({push_addr[31:2], 2'b00});
            qw.push_back(push_wen);
            qd.push_back(push_data);
         end
      end
   endtask

   // One clock: compare mid-cycle, advance the model at the edge, settle.
   task automatic cycle();
      @(negedge clk);
      check_outputs();
      @(posedge clk);
      update_model();
      #1;
   endtask

   task automatic set_push(input logic v, input logic [31:0] a, input logic [3:0] w,
                           input logic [31:0] d);
      push_valid = v; push_addr = a; push_wen = w; push_data = d;
   endtask

   task automatic drain(input string name);
      int k = 0;
      push_valid = 1'b0;
      dc_ready   = 1'b1;
      while (empty !== 1'b1 && k < 20) begin
         cycle();
         k++;
      end
      chk({name, "_drain_empty"}, {31'h0, empty}, 32'h1);
   endtask

   initial begin
      resetn = 1'b0; dc_ready = 1'b0; ld_valid = 1'b0; ld_addr = 32'h0; ld_ben = 4'h0;
      set_push(1'b0, 32'h0, 4'h0, 32'h0);
      cycle(); cycle();
      chk("rst_empty", {31'h0, empty}, 32'h1);
      chk("rst_full", {31'h0, full}, 32'h0);
      chk("rst_push_ready", {31'h0, push_ready}, 32'h1);
      chk("rst_dc_valid", {31'h0, dc_valid}, 32'h0);
      resetn = 1'b1;
      cycle();

      // Single store: visible next cycle, gone the cycle after.
      dc_ready = 1'b1;
      set_push(1'b1, 32'h1000_0004, 4'b1111, 32'hDEAD_BEEF);
      cycle();
      push_valid = 1'b0;
      #1;
      chk("t1_dc_valid", {31'h0, dc_valid}, 32'h1);
      chk("t1_dc_addr", dc_addr, 32'h1000_0004);
      chk("t1_dc_data", dc_data, 32'hDEAD_BEEF);
      cycle();
      chk("t1_empty", {31'h0, empty}, 32'h1);

      // Fill, hold a fifth push, single pop, then accept the fifth.
      dc_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         set_push(1'b1, 32'h5000 + 32'(4*i), 4'b1111, 32'hA000 + 32'(i));
         cycle();
      end
      set_push(1'b1, 32'h5010, 4'b1111, 32'hA004);
      #1;
      chk("t2_full", {31'h0, full}, 32'h1);
      chk("t2_push_ready", {31'h0, push_ready}, 32'h0);
      cycle();
      dc_ready = 1'b1;
      #1;
      chk("t2_no_bypass", {31'h0, push_ready}, 32'h0);
      cycle();
      dc_ready = 1'b0;
      #1;
      chk("t2_ready_after_pop", {31'h0, push_ready}, 32'h1);
      cycle();
      push_valid = 1'b0;
      #1;
      chk("t2_full_again", {31'h0, full}, 32'h1);
      chk("t2_head", dc_addr, 32'h5004);
      drain("t2");

      // Byte-lane overlap on loads.
      dc_ready = 1'b0;
      set_push(1'b1, 32'h2000, 4'b0011, 32'h0000_ABCD);
      cycle();
      push_valid = 1'b0;
      ld_valid = 1'b1; ld_addr = 32'h2002; ld_ben = 4'b1100;
      #1;
      chk("t3_no_overlap", {31'h0, ld_conflict}, 32'h0);
      cycle();
      ld_addr = 32'h2001; ld_ben = 4'b0010;
      #1;
      chk("t3_overlap", {31'h0, ld_conflict}, 32'h1);
      cycle();
      ld_addr = 32'h2000; ld_ben = 4'b0001; dc_ready = 1'b1;
      #1;
      chk("t3_popping_conflicts", {31'h0, ld_conflict}, 32'h1);
      cycle();
      ld_valid = 1'b0;
      drain("t3");

      // Zero-enable push is dropped.
      set_push(1'b1, 32'h6000, 4'b0000, 32'h1234_5678);
      cycle();
      push_valid = 1'b0;
      #1;
      chk("t4_dc_valid", {31'h0, dc_valid}, 32'h0);
      chk("t4_empty", {31'h0, empty}, 32'h1);

      // Steady three entries while pushing and popping every cycle.
      dc_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         set_push(1'b1, 32'h7000 + 32'(4*i), 4'b1111, 32'(i));
         cycle();
      end
      dc_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         set_push(1'b1, 32'h700C + 32'(4*k), 4'b1111, 32'(k + 3));
         cycle();
         chk("t5_head", dc_addr, 32'h7004 + 32'(4*k));
         chk("t5_head_data", dc_data, 32'(k + 1));
      end
      push_valid = 1'b0;
      cycle(); cycle();
      chk("t5_not_empty", {31'h0, empty}, 32'h0);
      cycle();
      chk("t5_empty", {31'h0, empty}, 32'h1);

`ifdef STORE_BUF_MERGE_EN
      dc_ready = 1'b0;
      set_push(1'b1, 32'h3000, 4'b0001, 32'h0000_0011);
      cycle();
      set_push(1'b1, 32'h3001, 4'b0010, 32'h0000_2200);
      cycle();
      push_valid = 1'b0;
      #1;
      chk("t6_merge_wen", {28'h0, dc_wen}, {28'h0, 4'b0011});
      chk("t6_merge_data", dc_data, 32'h0000_2211);
      cycle();
      dc_ready = 1'b1;
      cycle();
      chk("t6_single_entry", {31'h0, empty}, 32'h1);
`endif

      // Randomized traffic over a small address pool, with occasional resets.
      for (int c = 0; c < 2000; c++) begin
         resetn     = ($urandom_range(0, 99) != 0);
         push_valid = ($urandom_range(0, 2) != 0);
         push_addr  = 32'h4000 + 32'(4 * $urandom_range(0, 3)) + 32'($urandom_range(0, 3));
         push_wen   = 4'($urandom_range(0, 15));
         push_data  = $urandom;
         dc_ready   = ($urandom_range(0, 2) == 0);
         ld_valid   = ($urandom_range(0, 1) != 0);
         ld_addr    = 32'h4000 + 32'(4 * $urandom_range(0, 4)) + 32'($urandom_range(0, 3));
         ld_ben     = 4'($urandom_range(0, 15));
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
